// File: rtl/stack_unit_pkg.sv
// -----------------------------------------------------------------------------
// stack_unit_pkg
// Shared definitions for the parametrised LIFO operand stack.
//   - cmd_e       : one-hot-free command encoding, ordered by decode priority
//   - DEF_WIDTH   : default data word width
//   - DEF_DEPTH   : default number of stack entries
//   - cmd_decode  : fixed-priority command selector (replace > push > pop >
//                   tos > swap > idle)
// -----------------------------------------------------------------------------
package stack_unit_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_REPL = 3'd1,
        CMD_PUSH = 3'd2,
        CMD_POP  = 3'd3,
        CMD_TOS  = 3'd4,
        CMD_SWAP = 3'd5
    } cmd_e;

    // Exactly one command per cycle; lower-priority requests are dropped.
    function automatic cmd_e cmd_decode(
        input logic push,
        input logic pop,
        input logic tos,
        input logic swap
    );
        cmd_e cmd;
        if (push && pop) begin
            cmd = CMD_REPL;
        end else if (push) begin
            cmd = CMD_PUSH;
        end else if (pop) begin
            cmd = CMD_POP;
        end else if (tos) begin
            cmd = CMD_TOS;
        end else if (swap) begin
            cmd = CMD_SWAP;
        end else begin
            cmd = CMD_IDLE;
        end
        return cmd;
    endfunction

endpackage : stack_unit_pkg

// File: rtl/stack_regfile.sv
// -----------------------------------------------------------------------------
// stack_regfile
// DEPTH x WIDTH register array backing the operand stack. Contents are not
// reset; the owner guards every read with its entry count.
// Ports:
//   clk                 : rising-edge clock
//   we_a/addr_a/data_a  : synchronous write port A (wins on address collision)
//   we_b/addr_b/data_b  : synchronous write port B
//   rd_addr0 -> rd_data0: asynchronous read port 0 (top of stack)
//   rd_addr1 -> rd_data1: asynchronous read port 1 (entry below top)
// -----------------------------------------------------------------------------
module stack_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             we_b,
    input  logic [AW-1:0]    addr_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic [AW-1:0]    rd_addr0,
    output logic [WIDTH-1:0] rd_data0,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage update: port B written first so a colliding port A write wins.
    always_ff @(posedge clk) begin
        if (we_b) begin
            mem_r[addr_b] <= data_b;
        end
        if (we_a) begin
            mem_r[addr_a] <= data_a;
        end
    end

    assign rd_data0 = mem_r[rd_addr0];
    assign rd_data1 = mem_r[rd_addr1];

endmodule : stack_regfile

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
// Parametrised LIFO operand stack for the stack-machine datapath.
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   push/pop/tos/swap: commands (priority: push&pop replace, push, pop, tos, swap)
//   clr_err         : clear the sticky error flags (an error in the same
//                     cycle wins)
//   d_in            : push / replace data
//   d_out           : registered result (popped / top / swapped-top value)
//   count           : number of entries, 0..DEPTH
//   empty, full     : registered status, updated on the same edge as count
//   err_ovf, err_udf: sticky overflow / underflow flags
// A rejected command leaves storage, count and d_out untouched.
// -----------------------------------------------------------------------------
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             swap,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             err_ovf,
    output logic             err_udf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_e             cmd_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [WIDTH-1:0] d_out_r;
    logic [WIDTH-1:0] d_out_nxt_s;
    logic             empty_r;
    logic             full_r;
    logic             err_ovf_r;
    logic             err_udf_r;
    logic             ovf_set_s;
    logic             udf_set_s;

    logic             has_one_s;
    logic             has_two_s;
    logic             is_full_s;
    logic [CNT_W-1:0] top_idx_s;
    logic [CNT_W-1:0] nxt_idx_s;
    logic [AW-1:0]    top_addr_s;
    logic [AW-1:0]    nxt_addr_s;
    logic [AW-1:0]    push_addr_s;

    logic             we_a_s;
    logic [AW-1:0]    addr_a_s;
    logic [WIDTH-1:0] data_a_s;
    logic             we_b_s;
    logic [AW-1:0]    addr_b_s;
    logic [WIDTH-1:0] data_b_s;
    logic [WIDTH-1:0] rd_top_s;
    logic [WIDTH-1:0] rd_nxt_s;

    assign cmd_s     = cmd_decode(push, pop, tos, swap);
    assign has_one_s = (count_r != {CNT_W{1'b0}});
    assign has_two_s = (count_r >= CNT_W'(2));
    assign is_full_s = (count_r == CNT_W'(DEPTH));

    // count-1 / count-2 only index storage when the guards above hold, so the
    // wrap on a small count is never observed.
    assign top_idx_s   = count_r - CNT_W'(1);
    assign nxt_idx_s   = count_r - CNT_W'(2);
    assign top_addr_s  = top_idx_s[AW-1:0];
    assign nxt_addr_s  = nxt_idx_s[AW-1:0];
    assign push_addr_s = count_r[AW-1:0];

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .we_a     (we_a_s),
        .addr_a   (addr_a_s),
        .data_a   (data_a_s),
        .we_b     (we_b_s),
        .addr_b   (addr_b_s),
        .data_b   (data_b_s),
        .rd_addr0 (top_addr_s),
        .rd_data0 (rd_top_s),
        .rd_addr1 (nxt_addr_s),
        .rd_data1 (rd_nxt_s)
    );

    // Command execution: next count, next d_out, storage writes and error events.
    always_comb begin
        count_nxt_s = count_r;
        d_out_nxt_s = d_out_r;
        ovf_set_s   = 1'b0;
        udf_set_s   = 1'b0;
        we_a_s      = 1'b0;
        addr_a_s    = top_addr_s;
        data_a_s    = d_in;
        we_b_s      = 1'b0;
        addr_b_s    = nxt_addr_s;
        data_b_s    = rd_top_s;
        case (cmd_s)
            CMD_REPL: begin
                if (has_one_s) begin
                    d_out_nxt_s = rd_top_s;
                    we_a_s      = 1'b1;
                    addr_a_s    = top_addr_s;
                    data_a_s    = d_in;
                end else begin
                    udf_set_s = 1'b1;
                end
            end
            CMD_PUSH: begin
                if (!is_full_s) begin
                    we_a_s      = 1'b1;
                    addr_a_s    = push_addr_s;
                    data_a_s    = d_in;
                    count_nxt_s = count_r + CNT_W'(1);
                end else begin
                    ovf_set_s = 1'b1;
                end
            end
            CMD_POP: begin
                if (has_one_s) begin
                    d_out_nxt_s = rd_top_s;
                    count_nxt_s = count_r - CNT_W'(1);
                end else begin
                    udf_set_s = 1'b1;
                end
            end
            CMD_TOS: begin
                if (has_one_s) begin
                    d_out_nxt_s = rd_top_s;
                end else begin
                    udf_set_s = 1'b1;
                end
            end
            CMD_SWAP: begin
                if (has_two_s) begin
                    // Both writes land on the same edge, so the exchange is atomic.
                    we_a_s      = 1'b1;
                    addr_a_s    = top_addr_s;
                    data_a_s    = rd_nxt_s;
                    we_b_s      = 1'b1;
                    addr_b_s    = nxt_addr_s;
                    data_b_s    = rd_top_s;
                    d_out_nxt_s = rd_nxt_s;
                end else begin
                    udf_set_s = 1'b1;
                end
            end
            CMD_IDLE: begin
                count_nxt_s = count_r;
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // State registers: count, result, status decode and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= {CNT_W{1'b0}};
            d_out_r   <= {WIDTH{1'b0}};
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            err_ovf_r <= 1'b0;
            err_udf_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            d_out_r <= d_out_nxt_s;
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
            // Set has priority over clear when both happen in one cycle.
            if (ovf_set_s) begin
                err_ovf_r <= 1'b1;
            end else if (clr_err) begin
                err_ovf_r <= 1'b0;
            end
            if (udf_set_s) begin
                err_udf_r <= 1'b1;
            end else if (clr_err) begin
                err_udf_r <= 1'b0;
            end
        end
    end

    assign d_out   = d_out_r;
    assign count   = count_r;
    assign empty   = empty_r;
    assign full    = full_r;
    assign err_ovf = err_ovf_r;
    assign err_udf = err_udf_r;

endmodule : stack_unit

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
// Directed bench for stack_unit (WIDTH=8, DEPTH=4) with hand-computed
// expected values.
// -----------------------------------------------------------------------------
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             tos;
    logic             swap;
    logic             clr_err;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             err_ovf;
    logic             err_udf;

    int n_checks;
    int n_pass;

    stack_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .tos     (tos),
        .swap    (swap),
        .clr_err (clr_err),
        .d_in    (d_in),
        .d_out   (d_out),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .err_ovf (err_ovf),
        .err_udf (err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One command cycle: drive inputs, let the edge sample them, sample #1 later.
    task automatic cmd(input logic p_push, input logic p_pop, input logic p_tos,
                       input logic p_swap, input logic p_clr, input logic [7:0] p_din);
        push    = p_push;
        pop     = p_pop;
        tos     = p_tos;
        swap    = p_swap;
        clr_err = p_clr;
        d_in    = p_din;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        tos     = 1'b0;
        swap    = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_push(input logic [7:0] v); cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, v); endtask
    task automatic do_pop();  cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); endtask
    task automatic do_tos();  cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); endtask
    task automatic do_swap(); cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); endtask
    task automatic do_clr();  cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00); endtask

    initial begin
        logic [7:0] fill_v [4];
        fill_v[0] = 8'h01; fill_v[1] = 8'h02; fill_v[2] = 8'h03; fill_v[3] = 8'h04;
        n_checks = 0;
        n_pass   = 0;
        push = 1'b0; pop = 1'b0; tos = 1'b0; swap = 1'b0; clr_err = 1'b0;
        d_in = 8'h00;

        // Reset values
        rst = 1'b1;
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_dout",  32'(d_out), 32'd0);
        check("rst_ovf",   32'(err_ovf), 32'd0);
        check("rst_udf",   32'(err_udf), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LIFO order
        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        check("lifo_count3", 32'(count), 32'd3);
        check("lifo_not_empty", 32'(empty), 32'd0);
        do_pop(); check("lifo_pop1", 32'(d_out), 32'h33);
        do_pop(); check("lifo_pop2", 32'(d_out), 32'h22);
        do_pop(); check("lifo_pop3", 32'(d_out), 32'h11);
        check("lifo_empty", 32'(empty), 32'd1);
        check("lifo_count0", 32'(count), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 4; i++) begin
            do_push(fill_v[i]);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        do_push(8'hAA);
        check("ovf_flag", 32'(err_ovf), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_dout_kept", 32'(d_out), 32'h11);
        do_tos();
        check("ovf_top_kept", 32'(d_out), 32'h04);
        do_clr();
        check("ovf_cleared", 32'(err_ovf), 32'd0);

        // Reset mid-burst, held for two cycles with a push pending
        rst = 1'b1;
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h56);
        rst = 1'b0;
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_empty", 32'(empty), 32'd1);
        check("mrst_full",  32'(full),  32'd0);
        check("mrst_dout",  32'(d_out), 32'd0);

        // Back-to-back push/pop, then underflow on empty pop
        do_push(8'h99);
        do_pop();
        check("b2b_pop", 32'(d_out), 32'h99);
        do_pop();
        check("udf_pop_flag", 32'(err_udf), 32'd1);
        check("udf_pop_dout", 32'(d_out), 32'h99);
        check("udf_pop_count", 32'(count), 32'd0);
        do_clr();
        check("udf_cleared", 32'(err_udf), 32'd0);

        // Swap with a single entry is rejected
        do_push(8'h66);
        do_swap();
        check("udf_swap_flag", 32'(err_udf), 32'd1);
        check("udf_swap_count", 32'(count), 32'd1);
        check("udf_swap_dout", 32'(d_out), 32'h99);
        do_tos();
        check("udf_swap_top", 32'(d_out), 32'h66);
        do_clr();
        do_pop();
        check("udf_swap_pop", 32'(d_out), 32'h66);

        // Swap and tos
        do_push(8'h05); do_push(8'h07);
        do_swap();
        check("swap_dout", 32'(d_out), 32'h05);
        check("swap_count", 32'(count), 32'd2);
        check("swap_noerr", 32'(err_udf), 32'd0);
        do_pop(); check("swap_pop1", 32'(d_out), 32'h05);
        do_pop(); check("swap_pop2", 32'(d_out), 32'h07);

        // Replace (push+pop) then tos
        do_push(8'h40);
        cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41);
        check("repl_dout", 32'(d_out), 32'h40);
        check("repl_count", 32'(count), 32'd1);
        do_tos();
        check("repl_tos", 32'(d_out), 32'h41);

        // Push beats tos: count grows, d_out unchanged
        cmd(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h42);
        check("prio_count", 32'(count), 32'd2);
        check("prio_dout", 32'(d_out), 32'h41);
        do_pop(); check("prio_pop1", 32'(d_out), 32'h42);
        do_pop(); check("prio_pop2", 32'(d_out), 32'h41);

        // Replace on empty underflows without touching d_out
        cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        check("repl_empty_udf", 32'(err_udf), 32'd1);
        check("repl_empty_count", 32'(count), 32'd0);
        check("repl_empty_dout", 32'(d_out), 32'h41);

        // clr_err with a simultaneous underflow: set wins
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check("clr_vs_set", 32'(err_udf), 32'd1);
        do_clr();
        check("clr_final", 32'(err_udf), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_stack_unit
